// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the three handshake buses around the memory port arbiter:
//   - fetch requester  : if_req/if_addr   -> if_ack/if_rdata
//   - data requester   : dm_req/dm_we/dm_addr/dm_wdata -> dm_ack/dm_rdata
//   - shared memory    : mem_req/mem_we/mem_addr/mem_wdata -> mem_ack/mem_rdata
// Modports:
//   slave  - the arbiter's view (takes requests, drives acks and memory side)
//   master - the environment's view (requesters plus memory model)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, variable-latency memory between the instruction
// fetch requester and the data requester. One access outstanding at a time;
// data wins by default, but after MAX_DM_STREAK consecutive data grants with
// fetch waiting, fetch is forced. A watchdog ends any wait lasting TIMEOUT
// cycles, returning zero data and setting a sticky error flag.
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous, active-high reset
//   bus            mem_port_arbiter_if.slave (requester and memory buses)
//   timeout_err_o  sticky watchdog flag, cleared only by reset
// All outputs are registered.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int MAX_DM_STREAK = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_port_arbiter_if.slave bus,
  output logic              timeout_err_o
);

  localparam int SW = (MAX_DM_STREAK > 0) ? $clog2(MAX_DM_STREAK + 1) : 1;
  localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);
  localparam logic [SW-1:0] STREAK_ONE = SW'(1);
  localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);
  localparam logic [WW-1:0] WDOG_ONE   = WW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT_I = 3'd1,
    WAIT_D = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          if_ack_q, if_ack_d;
  logic          dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          timeout_err_q, timeout_err_d;

  logic          grant_d_s;
  logic          ack_ok_s;
  logic          timeout_s;
  logic [DW-1:0] resp_data_s;

  // Data wins unless fetch is also waiting and the data streak hit its cap.
  assign grant_d_s   = bus.dm_req && (!bus.if_req || (streak_q < STREAK_MAX));
  // An ack in the same cycle as mem_req cannot belong to this access.
  assign ack_ok_s    = bus.mem_ack && !mem_req_q;
  assign timeout_s   = !ack_ok_s && (wdog_q == WDOG_LAST);
  // Writes and aborted accesses return zero.
  assign resp_data_s = (ack_ok_s && !mem_we_q) ? bus.mem_rdata : {DW{1'b0}};

  // Next-state logic: arbitration in IDLE, ack/watchdog handling in WAIT_x.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    wdog_d        = wdog_q;
    if_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    mem_req_d     = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        if (grant_d_s) begin
          state_d     = WAIT_D;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr;
          mem_wdata_d = bus.dm_wdata;
          wdog_d      = {WW{1'b0}};
          // The streak only counts while fetch is being held off.
          streak_d    = bus.if_req ? (streak_q + STREAK_ONE) : {SW{1'b0}};
        end else if (bus.if_req) begin
          state_d     = WAIT_I;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr;
          mem_wdata_d = {DW{1'b0}};
          wdog_d      = {WW{1'b0}};
          streak_d    = {SW{1'b0}};
        end else begin
          state_d     = IDLE;
        end
      end

      WAIT_I, WAIT_D: begin
        if (ack_ok_s || timeout_s) begin
          if (state_q == WAIT_I) begin
            state_d    = RESP_I;
            if_ack_d   = 1'b1;
            if_rdata_d = resp_data_s;
          end else begin
            state_d    = RESP_D;
            dm_ack_d   = 1'b1;
            dm_rdata_d = resp_data_s;
          end
          timeout_err_d = timeout_err_q | timeout_s;
        end else begin
          wdog_d = wdog_q + WDOG_ONE;
        end
      end

      // Requester drops req on seeing ack, so requests are not sampled here.
      RESP_I, RESP_D: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      streak_q      <= {SW{1'b0}};
      wdog_q        <= {WW{1'b0}};
      if_ack_q      <= 1'b0;
      dm_ack_q      <= 1'b0;
      if_rdata_q    <= {DW{1'b0}};
      dm_rdata_q    <= {DW{1'b0}};
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= {AW{1'b0}};
      mem_wdata_q   <= {DW{1'b0}};
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      wdog_q        <= wdog_d;
      if_ack_q      <= if_ack_d;
      dm_ack_q      <= dm_ack_d;
      if_rdata_q    <= if_rdata_d;
      dm_rdata_q    <= dm_rdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.if_ack     = if_ack_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.dm_ack     = dm_ack_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign timeout_err_o  = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: lone fetch, simultaneous requests,
// starvation guard, watchdog timeout, reset mid-access, early/stray acks.
// Inputs driven and outputs sampled just after the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TMO  = 64;

  logic clk_s = 1'b0;
  logic rst_s;
  logic timeout_err_s;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)
  ) dut (
    .clk_i        (clk_s),
    .rst_i        (rst_s),
    .bus          (bus),
    .timeout_err_o(timeout_err_s)
  );

  always #5 clk_s = ~clk_s;

  int n_cmp = 0;
  int n_err = 0;

  // Memory model controls.
  logic          mem_auto_s = 1'b1;
  int            mem_lat    = 2;
  logic [DW-1:0] mem_data_s = 32'h0000_0000;
  logic          man_ack_s  = 1'b0;
  logic          auto_ack_s = 1'b0;
  int            ack_cd     = 0;

  assign bus.mem_ack   = auto_ack_s | man_ack_s;
  assign bus.mem_rdata = mem_data_s;

  // Event monitors.
  int cyc = 0;
  int mreq_n = 0, if_ack_n = 0, dm_ack_n = 0;
  int mreq_cyc = 0, mack_cyc = 0, if_ack_cyc = 0, dm_ack_cyc = 0;
  logic [AW-1:0] grant_addr[$];
  logic          grant_we[$];
  logic [DW-1:0] grant_wdata[$];

  // Memory responder plus event logging, once per falling edge.
  always @(negedge clk_s) begin
    cyc++;
    auto_ack_s = 1'b0;
    if (ack_cd > 0) begin
      ack_cd--;
      if (ack_cd == 0) begin
        auto_ack_s = 1'b1;
        mack_cyc   = cyc;
      end
    end
    if (bus.mem_req) begin
      mreq_n++;
      mreq_cyc = cyc;
      grant_addr.push_back(bus.mem_addr);
      grant_we.push_back(bus.mem_we);
      grant_wdata.push_back(bus.mem_wdata);
      if (mem_auto_s) ack_cd = mem_lat;
    end
    if (bus.if_ack) begin
      if_ack_n++;
      if_ack_cyc = cyc;
    end
    if (bus.dm_ack) begin
      dm_ack_n++;
      dm_ack_cyc = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_s);
    #1;
  endtask

  task automatic wait_if(input int base, input string tag);
    int k = 0;
    while (if_ack_n == base && k < 200) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(if_ack_n - base), 64'd1);
  endtask

  task automatic wait_dm(input int base, input string tag);
    int k = 0;
    while (dm_ack_n == base && k < 200) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(dm_ack_n - base), 64'd1);
  endtask

  task automatic wait_mreq(input int base, input string tag);
    int k = 0;
    while (mreq_n == base && k < 20) begin
      tick();
      k++;
    end
    check_eq(tag, 64'(mreq_n - base), 64'd1);
  endtask

  task automatic check_all_zero(input string pfx);
    check_eq({pfx, "_if_ack"},    64'(bus.if_ack),    64'd0);
    check_eq({pfx, "_dm_ack"},    64'(bus.dm_ack),    64'd0);
    check_eq({pfx, "_mem_req"},   64'(bus.mem_req),   64'd0);
    check_eq({pfx, "_mem_we"},    64'(bus.mem_we),    64'd0);
    check_eq({pfx, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check_eq({pfx, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check_eq({pfx, "_if_rdata"},  64'(bus.if_rdata),  64'd0);
    check_eq({pfx, "_dm_rdata"},  64'(bus.dm_rdata),  64'd0);
    check_eq({pfx, "_tmo_err"},   64'(timeout_err_s), 64'd0);
  endtask

  int b_if, b_dm, b_mreq, g0, k3, last_if, last_dm, ack_tick;
  logic if_rr, dm_rr;
  logic [9:0] t3_is_i;

  // Hard stop in case something hangs outside the bounded waits.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_s        = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = 32'h0000_0000;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 32'h0000_0000;
    bus.dm_wdata = 32'h0000_0000;
    repeat (3) tick();
    check_all_zero("reset");
    rst_s = 1'b0;
    tick();

    // 1: lone fetch, memory latency 2.
    mem_auto_s = 1'b1;
    mem_lat    = 2;
    mem_data_s = 32'h2010_0005;
    b_if = if_ack_n; b_dm = dm_ack_n; b_mreq = mreq_n; g0 = grant_addr.size();
    bus.if_addr = 32'h0000_0040;
    bus.if_req  = 1'b1;
    wait_if(b_if, "t1_if_ack_seen");
    bus.if_req = 1'b0;
    check_eq("t1_if_rdata",      64'(bus.if_rdata), 64'h2010_0005);
    check_eq("t1_ack_after_mack", 64'(if_ack_cyc - mack_cyc), 64'd1);
    check_eq("t1_ack_after_mreq", 64'(if_ack_cyc - mreq_cyc), 64'd3);
    repeat (3) tick();
    check_eq("t1_mreq_count", 64'(mreq_n - b_mreq), 64'd1);
    check_eq("t1_mem_we",     64'(grant_we[g0]),    64'd0);
    check_eq("t1_mem_addr",   64'(grant_addr[g0]),  64'h40);
    check_eq("t1_if_ack_cnt", 64'(if_ack_n - b_if), 64'd1);
    check_eq("t1_dm_ack_cnt", 64'(dm_ack_n - b_dm), 64'd0);

    // 2: simultaneous requests; data write first, then fetch.
    mem_data_s = 32'h1234_5678;
    b_if = if_ack_n; b_dm = dm_ack_n; g0 = grant_addr.size();
    bus.if_addr  = 32'h0000_0080;
    bus.if_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 32'h0000_0100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_req   = 1'b1;
    wait_dm(b_dm, "t2_dm_ack_seen");
    bus.dm_req = 1'b0;
    check_eq("t2_dm_rdata",   64'(bus.dm_rdata),    64'd0);
    check_eq("t2_first_addr", 64'(grant_addr[g0]),  64'h100);
    check_eq("t2_first_we",   64'(grant_we[g0]),    64'd1);
    check_eq("t2_first_wdat", 64'(grant_wdata[g0]), 64'hDEAD_BEEF);
    check_eq("t2_if_pending", 64'(if_ack_n - b_if), 64'd0);
    wait_if(b_if, "t2_if_ack_seen");
    bus.if_req = 1'b0;
    check_eq("t2_second_addr", 64'(grant_addr[g0 + 1]), 64'h80);
    check_eq("t2_second_we",   64'(grant_we[g0 + 1]),   64'd0);
    check_eq("t2_if_rdata",    64'(bus.if_rdata),       64'h1234_5678);
    tick();

    // 3: starvation guard; both requesters re-raise after each ack.
    mem_lat    = 1;
    mem_data_s = 32'hCAFE_0001;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0100;
    bus.if_addr = 32'h0000_0080;
    b_if = if_ack_n; b_dm = dm_ack_n; g0 = grant_addr.size();
    last_if = if_ack_n; last_dm = dm_ack_n;
    if_rr = 1'b0; dm_rr = 1'b0; k3 = 0;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    while (((if_ack_n - b_if) < 2 || (dm_ack_n - b_dm) < 8) && k3 < 400) begin
      tick();
      k3++;
      if (if_rr) begin bus.if_req = 1'b1; if_rr = 1'b0; end
      if (dm_rr) begin bus.dm_req = 1'b1; dm_rr = 1'b0; end
      if (if_ack_n != last_if) begin
        last_if = if_ack_n;
        bus.if_req = 1'b0;
        if_rr = ((if_ack_n - b_if) < 2);
      end
      if (dm_ack_n != last_dm) begin
        last_dm = dm_ack_n;
        bus.dm_req = 1'b0;
        dm_rr = ((dm_ack_n - b_dm) < 8);
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    repeat (3) tick();
    check_eq("t3_grant_count", 64'(grant_addr.size() - g0), 64'd10);
    // Bit i set = fetch expected at grant i: D D D D I D D D D I.
    t3_is_i = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      check_eq($sformatf("t3_grant%0d", i), 64'(grant_addr[g0 + i]),
               t3_is_i[i] ? 64'h80 : 64'h100);
    end
    check_eq("t3_dm_rdata", 64'(bus.dm_rdata), 64'hCAFE_0001);

    // 4: watchdog timeout on a data read, then a normal fetch.
    check_eq("t4_err_before", 64'(timeout_err_s), 64'd0);
    mem_auto_s = 1'b0;
    b_dm = dm_ack_n;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0104;
    bus.dm_req  = 1'b1;
    wait_dm(b_dm, "t4_dm_ack_seen");
    bus.dm_req = 1'b0;
    check_eq("t4_ack_latency", 64'(dm_ack_cyc - mreq_cyc), 64'd64);
    check_eq("t4_dm_rdata",    64'(bus.dm_rdata),          64'd0);
    check_eq("t4_err_set",     64'(timeout_err_s),         64'd1);
    tick();
    mem_auto_s = 1'b1;
    mem_lat    = 2;
    mem_data_s = 32'h0BAD_F00D;
    b_if = if_ack_n;
    bus.if_addr = 32'h0000_00C0;
    bus.if_req  = 1'b1;
    wait_if(b_if, "t4_fetch_seen");
    bus.if_req = 1'b0;
    check_eq("t4_fetch_rdata", 64'(bus.if_rdata), 64'h0BAD_F00D);
    check_eq("t4_err_sticky",  64'(timeout_err_s), 64'd1);
    tick();

    // 5: reset while waiting on a fetch; stray ack afterwards.
    mem_auto_s = 1'b0;
    b_if = if_ack_n; b_mreq = mreq_n;
    bus.if_addr = 32'h0000_0044;
    bus.if_req  = 1'b1;
    wait_mreq(b_mreq, "t5_granted");
    tick();
    rst_s      = 1'b1;
    bus.if_req = 1'b0;
    tick();
    rst_s = 1'b0;
    check_all_zero("t5_rst");
    tick();
    man_ack_s = 1'b1;
    tick();
    man_ack_s = 1'b0;
    repeat (4) tick();
    check_eq("t5_no_if_ack", 64'(if_ack_n - b_if), 64'd0);
    check_eq("t5_no_mreq",   64'(mreq_n - b_mreq), 64'd1);
    check_all_zero("t5_post");

    // 6: stray ack in IDLE, early ack with mem_req, then a valid ack.
    mem_data_s = 32'h55AA_55AA;
    b_dm = dm_ack_n; b_if = if_ack_n; b_mreq = mreq_n;
    man_ack_s = 1'b1;
    tick();
    man_ack_s = 1'b0;
    tick();
    check_eq("t6_idle_mreq", 64'(mreq_n - b_mreq), 64'd0);
    check_eq("t6_idle_ack",  64'(dm_ack_n - b_dm + if_ack_n - b_if), 64'd0);
    bus.dm_we   = 1'b0;
    bus.dm_addr = 32'h0000_0108;
    bus.dm_req  = 1'b1;
    wait_mreq(b_mreq, "t6_granted");
    man_ack_s = 1'b1;
    tick();
    man_ack_s = 1'b0;
    repeat (4) tick();
    check_eq("t6_early_ignored", 64'(dm_ack_n - b_dm), 64'd0);
    man_ack_s = 1'b1;
    ack_tick  = cyc;
    tick();
    man_ack_s = 1'b0;
    check_eq("t6_dm_ack_cnt",  64'(dm_ack_n - b_dm),        64'd1);
    check_eq("t6_ack_latency", 64'(dm_ack_cyc - ack_tick),  64'd1);
    check_eq("t6_dm_rdata",    64'(bus.dm_rdata),           64'h55AA_55AA);
    check_eq("t6_mem_addr",    64'(bus.mem_addr),           64'h108);
    bus.dm_req = 1'b0;
    repeat (2) tick();
    check_eq("t6_mreq_total",  64'(mreq_n - b_mreq),        64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, variable-latency memory between the instruction-fetch (IF) requester and the data-memory (MEM stage) requester of the pipelined CPU.
- Allows at most one outstanding access at a time.
- Data requests win by default; a streak counter guarantees fetch progress.
- A watchdog terminates accesses whose acknowledge never arrives.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_DM_STREAK, 4, consecutive data grants allowed while IF is waiting before IF is forced.
- TIMEOUT, 64, cycles in a wait state before the access is aborted.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle pulse; fetch complete.
- if_rdata  out  DW  fetched word; valid when if_ack is high.
- dm_req  in  1  data request; held high until dm_ack.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  write data.
- dm_ack  out  1  one-cycle pulse; data access complete.
- dm_rdata  out  DW  read word; valid when dm_ack is high; 0 for writes.
- mem_req  out  1  one-cycle pulse to memory.
- mem_we  out  1  write enable, qualified by mem_req.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion pulse.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- timeout_err  out  1  sticky flag; set on any timeout.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- FSM states: IDLE, WAIT_I, WAIT_D, RESP_I, RESP_D.
- Reset:
  - State goes to IDLE.
  - if_ack, dm_ack, mem_req, mem_we and timeout_err go to 0.
  - All data/address outputs go to 0.
  - Streak counter and watchdog go to 0.
  - Reset wins over every other event. If reset occurs mid-access, the access is dropped with no ack, and a later stray mem_ack is ignored.
- IDLE arbitration, evaluated each cycle in IDLE:
  - If both requests are high and streak < MAX_DM_STREAK, grant D and increment streak.
  - If both requests are high and streak == MAX_DM_STREAK, grant I.
  - If only dm_req is high, grant D; streak stays 0 (the cap only applies while IF is waiting).
  - If only if_req is high, grant I.
  - Granting I clears streak.
  - No request: stay in IDLE.
- Grant effect (next cycle):
  - mem_req = 1 for exactly one cycle; mem_addr, mem_we and mem_wdata are latched from the winner.
  - For I: mem_we = 0.
  - State goes to WAIT_I or WAIT_D; watchdog is cleared.
  - mem_addr, mem_we and mem_wdata hold until the next grant.
- WAIT_x:
  - mem_ack is honoured from the cycle after mem_req onward. An ack coinciding with mem_req is ignored.
  - On mem_ack, capture mem_rdata (writes capture 0) and go to RESP_x.
  - Otherwise the watchdog increments.
  - When watchdog == TIMEOUT-1 without an ack: go to RESP_x with rdata = 0 and set timeout_err.
- RESP_x:
  - The matching ack output is high for this single cycle, with rdata valid.
  - The arbiter does not sample requests in this cycle, since the requester drops req on seeing ack.
  - Next state is IDLE.
- mem_ack received in IDLE or RESP_x is ignored.
- Latency:
  - Request seen in IDLE at cycle t gives mem_req at t+1.
  - Ack arriving at cycle u (u ≥ t+2) gives requester ack at u+1.
  - Minimum transaction is 4 cycles: t, t+1, t+2 (ack), t+3 (ack out).
  - The next grant decision is made at t+4.
- rdata outputs hold their last value between acks.
- timeout_err clears only on reset.

Test Plan:
1. Lone fetch: if_req=1, addr=0x0000_0040; memory acks 2 cycles after mem_req with 0x2010_0005.
   - mem_req pulses once with we=0 and addr=0x40.
   - if_ack pulses once with if_rdata=0x2010_0005, exactly 1 cycle after mem_ack; dm_ack stays 0.
2. Simultaneous requests: if_req and dm_req both high from cycle 0; dm_we=1, addr=0x100, wdata=0xDEADBEEF.
   - D is granted first: mem_we=1 and wdata=0xDEADBEEF.
   - dm_ack comes with dm_rdata=0; IF is granted next.
3. Starvation guard: dm_req held continuously (re-raised after each ack) with if_req high; MAX_DM_STREAK=4.
   - Grant order is D, D, D, D, I, D…; streak resets after the I grant.
4. Timeout: grant D, mem_ack never asserted, TIMEOUT=64.
   - dm_ack asserts 64 cycles after entering WAIT_D with dm_rdata=0; timeout_err=1 and stays 1.
   - A following fetch still completes normally.
5. Reset mid-access: reset asserted in WAIT_I, then mem_ack arrives 1 cycle after reset deasserts.
   - No if_ack; state is IDLE; all outputs are 0; the stray ack is ignored.
6. Early/stray acks: mem_ack high in the same cycle as mem_req, and again while in IDLE.
   - Both are ignored; the transaction completes only on the next valid mem_ack.
